ex_issue_ctrl: RTL

- EX-stage sequencer between the ID/EX register and the EX/MEM register.
- Accepts one decoded EX operation (12-bit exOp bundle plus operands) per valid/ready handshake and selects ALU sources.
- Executes single-cycle ALU/branch ops directly; runs shifts iteratively, SHIFT_STEP bits per cycle.
- Backpressures the decode stage while busy or while the downstream holds a result; honours pipeline flush.

---
 rtl/ex_issue_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ex_issue_ctrl.sv
// EX-stage issue controller: takes one decoded op per handshake, resolves ALU
// and branch results in one cycle, and runs shifts iteratively SHIFT_STEP bits
// per cycle while backpressuring decode. The result register doubles as the
// EX/MEM output skid, held until the downstream accepts it.
module ex_issue_ctrl #(
  parameter int XLEN       = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [11:0]     exOpIn,
  input  logic [XLEN-1:0] rs1Data,
  input  logic [XLEN-1:0] rs2Data,
  input  logic [XLEN-1:0] immData,
  input  logic [XLEN-1:0] pcIn,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] outResult,
  output logic            outBranchTaken,
  output logic [XLEN-1:0] outBranchTarget,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} stateT;

  localparam logic [5:0] STEP = 6'(SHIFT_STEP);

  stateT state, nextState;

  logic [2:0]      branchOp;
  logic [3:0]      aluOp;
  logic            aluSrcASelect, aluSrcBSelect, aluEn, branchEn, workEn;
  logic [XLEN-1:0] srcA, srcB;
  logic            accept, isShiftOp, startShift, loadNow, shiftDone;
  logic [4:0]      shamtIn;

  logic [XLEN-1:0] shVal, shNext, pendTarget;
  logic [5:0]      shRem, stepAmt, remNext;
  logic [3:0]      shOp;

  // Single-cycle ALU. Shift codes only reach here with a zero shift amount,
  // so they pass operand A through unchanged.
  function automatic logic [XLEN-1:0] aluResult(input logic [3:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    case (op)
      4'b0000: aluResult = a + b;
      4'b1000: aluResult = a - b;
      4'b0010: aluResult = XLEN'($signed(a) < $signed(b));
      4'b0011: aluResult = XLEN'(a < b);
      4'b0100: aluResult = a ^ b;
      4'b0110: aluResult = a | b;
      4'b0111: aluResult = a & b;
      4'b0001, 4'b0101, 4'b1101: aluResult = a;
      default: aluResult = '0;
    endcase
  endfunction

  function automatic logic branchTaken(input logic [2:0] op,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    case (op)
      3'b000:  branchTaken = (a == b);
      3'b001:  branchTaken = (a != b);
      3'b100:  branchTaken = ($signed(a) < $signed(b));
      3'b101:  branchTaken = ($signed(a) >= $signed(b));
      3'b110:  branchTaken = (a < b);
      3'b111:  branchTaken = (a >= b);
      default: branchTaken = 1'b0;
    endcase
  endfunction

  // One partial shift step; sra keeps replicating the current MSB, which is
  // the original sign bit because every step preserves it.
  function automatic logic [XLEN-1:0] shiftBy(input logic [3:0] op,
                                              input logic [XLEN-1:0] v,
                                              input logic [5:0] amt);
    case (op)
      4'b0001: shiftBy = v << amt;
      4'b0101: shiftBy = v >> amt;
      4'b1101: shiftBy = $unsigned($signed(v) >>> amt);
      default: shiftBy = v;
    endcase
  endfunction

  assign {branchOp, aluOp, aluSrcASelect, aluSrcBSelect, aluEn, branchEn, workEn} = exOpIn;

  assign srcA    = aluSrcASelect ? pcIn : rs1Data;
  assign srcB    = aluSrcBSelect ? immData : rs2Data;
  assign shamtIn = srcB[4:0];

  // HOLD only means the result is waiting; once outReady is up the old result
  // retires at the same edge a new op is accepted, so HOLD admits ops too.
  assign inReady = !rst && (state != SHIFT) && (!outValid || outReady) && !flush;
  assign accept  = inValid && inReady;

  assign isShiftOp  = (aluOp == 4'b0001) || (aluOp == 4'b0101) || (aluOp == 4'b1101);
  assign startShift = accept && workEn && aluEn && !branchEn && isShiftOp && (shamtIn != 5'd0);
  assign loadNow    = accept && workEn && !startShift;

  assign stepAmt   = (shRem < STEP) ? shRem : STEP;
  assign remNext   = shRem - stepAmt;
  assign shNext    = shiftBy(shOp, shVal, stepAmt);
  assign shiftDone = (state == SHIFT) && (remNext == 6'd0);

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // Next-state: flush wins, shifts park in SHIFT, unretired results park in HOLD.
  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (startShift)                nextState = SHIFT;
          else if (loadNow)              nextState = outReady ? IDLE : HOLD;
          else if (outValid && !outReady) nextState = HOLD;
          else                           nextState = IDLE;
        end
        SHIFT:   nextState = shiftDone ? IDLE : SHIFT;
        default: nextState = IDLE;
      endcase
    end
  end

  // Output register: load a new result, finish a shift, or retire on handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid        <= 1'b0;
      outResult       <= '0;
      outBranchTaken  <= 1'b0;
      outBranchTarget <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (loadNow) begin
      outValid        <= 1'b1;
      outResult       <= (branchEn || !aluEn) ? '0 : aluResult(aluOp, srcA, srcB);
      outBranchTaken  <= branchEn && branchTaken(branchOp, rs1Data, rs2Data);
      outBranchTarget <= pcIn + immData;
    end else if (shiftDone) begin
      outValid        <= 1'b1;
      outResult       <= shNext;
      outBranchTaken  <= 1'b0;
      outBranchTarget <= pendTarget;
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

  // Iterative shifter datapath; control above decides when its contents matter.
  always_ff @(posedge clk) begin
    if (startShift) begin
      shVal      <= srcA;
      shRem      <= {1'b0, shamtIn};
      shOp       <= aluOp;
      pendTarget <= pcIn + immData;
    end else if (state == SHIFT) begin
      shVal <= shNext;
      shRem <= remNext;
    end
  end

endmodule
